// File: rtl/score_display_scan.sv
// Scans three snapshotted BCD digits onto a 4-anode common-anode seven-segment display.
// Optional SCORE_LEADING_ZERO_BLANK_EN blanks leading zeros in slots 2 and 1.
module score_display_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int GAP_CYCLES  = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit2,
  input  logic [3:0] digit1,
  input  logic [3:0] digit0,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP_CYCLES);

  logic [CNT_W-1:0] cnt_p0;
  logic [1:0]       slot_p0;
  logic [3:0]       snap2_p0;
  logic [3:0]       snap1_p0;
  logic [3:0]       snap0_p0;
  logic [3:0]       an_p1;
  logic [6:0]       seg_p1;

  logic [3:0]       cur_digit;
  logic             cur_blank;
  logic [3:0]       an_nxt;
  logic [6:0]       seg_nxt;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // Stage p0: slot selection and guard-gap blanking from the current scan position
  always_comb begin
    cur_digit = snap0_p0;
    cur_blank = 1'b0;
    an_nxt    = 4'b1111;
    seg_nxt   = 7'b1111111;
    case (slot_p0)
      2'd1:    cur_digit = snap1_p0;
      2'd2:    cur_digit = snap2_p0;
      default: cur_digit = snap0_p0;
    endcase
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    // Invalid digits are nonzero, so only an exact 0 suppresses a leading slot.
    case (slot_p0)
      2'd2:    cur_blank = (snap2_p0 == 4'd0);
      2'd1:    cur_blank = (snap2_p0 == 4'd0) && (snap1_p0 == 4'd0);
      default: cur_blank = 1'b0;
    endcase
`endif
    if (cnt_p0 >= GAP_END) begin
      case (slot_p0)
        2'd0:    an_nxt = 4'b1110;
        2'd1:    an_nxt = 4'b1101;
        2'd2:    an_nxt = 4'b1011;
        default: an_nxt = 4'b1111;
      endcase
      seg_nxt = cur_blank ? 7'b1111111 : bcd_to_seg(cur_digit);
    end
  end

  // Stage p1: registered display drive; snapshot refreshes only on the frame wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p0   <= '0;
      slot_p0  <= 2'd0;
      snap2_p0 <= 4'd0;
      snap1_p0 <= 4'd0;
      snap0_p0 <= 4'd0;
      an_p1    <= 4'b1111;
      seg_p1   <= 7'b1111111;
    end else begin
      an_p1  <= an_nxt;
      seg_p1 <= seg_nxt;
      if (cnt_p0 == CNT_LAST) begin
        cnt_p0 <= '0;
        if (slot_p0 == 2'd2) begin
          slot_p0  <= 2'd0;
          snap2_p0 <= digit2;
          snap1_p0 <= digit1;
          snap0_p0 <= digit0;
        end else begin
          slot_p0 <= slot_p0 + 2'd1;
        end
      end else begin
        cnt_p0 <= cnt_p0 + CNT_W'(1);
      end
    end
  end

  assign an  = an_p1;
  assign seg = seg_p1;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_score_display_scan.sv
// Directed bench for score_display_scan with REFRESH_DIV=8, GAP_CYCLES=2.
module tb_score_display_scan;

  localparam logic [6:0] S0   = 7'b1000000;
  localparam logic [6:0] S3   = 7'b0110000;
  localparam logic [6:0] S4   = 7'b0011001;
  localparam logic [6:0] S5   = 7'b0010010;
  localparam logic [6:0] S7   = 7'b1111000;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] BL   = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] digit2, digit1, digit0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int errors = 0;
  int checks = 0;
  int k = 0;  // edges since reset release

  score_display_scan #(.REFRESH_DIV(8), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .digit2(digit2), .digit1(digit1), .digit0(digit0),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout k=%0d expected bench to finish", k);
    $fatal(1);
  end

  // Output after edge kk reflects cnt=(kk-1)%8, slot=((kk-1)/8)%3.
  function automatic logic [3:0] exp_an(int kk);
    int c, s;
    c = (kk - 1) % 8;
    s = ((kk - 1) / 8) % 3;
    if (c < 2) return 4'b1111;
    case (s)
      0:       return 4'b1110;
      1:       return 4'b1101;
      default: return 4'b1011;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(int kk, logic [6:0] s0, logic [6:0] s1, logic [6:0] s2);
    int c, s;
    c = (kk - 1) % 8;
    s = ((kk - 1) / 8) % 3;
    if (c < 2) return BL;
    case (s)
      0:       return s0;
      1:       return s1;
      default: return s2;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    digit2 = 4'd3; digit1 = 4'd4; digit0 = 4'd5;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (an !== 4'b1111 || seg !== BL || dp !== 1'b1) begin
        errors++;
        $display("FAIL reset_held an=%b seg=%b dp=%b expected an=1111 seg=1111111 dp=1", an, seg, dp);
      end
    end
    rst = 1'b0;
    k = 0;
    checks++;
    if (an !== 4'b1111 || seg !== BL) begin
      errors++;
      $display("FAIL reset_release an=%b seg=%b expected an=1111 seg=1111111", an, seg);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (an !== exp_an(k) || seg !== exp_seg(k, S0, S0, S0) || dp !== 1'b1) begin
        errors++;
        $display("FAIL reset_slot0 k=%0d an=%b seg=%b dp=%b expected an=%b seg=%b dp=1",
                 k, an, seg, dp, exp_an(k), exp_seg(k, S0, S0, S0));
      end
    end
  endtask

  task automatic test_first_frame();
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (an !== exp_an(k) || seg !== exp_seg(k, S0, S0, S0)) begin
        errors++;
        $display("FAIL first_frame k=%0d an=%b seg=%b expected an=%b seg=%b",
                 k, an, seg, exp_an(k), exp_seg(k, S0, S0, S0));
      end
    end
  endtask

  task automatic test_live_digits();
    for (int i = 0; i < 24; i++) begin
      step();
      checks++;
      if (an !== exp_an(k) || seg !== exp_seg(k, S5, S4, S3)) begin
        errors++;
        $display("FAIL live_digits k=%0d an=%b seg=%b expected an=%b seg=%b",
                 k, an, seg, exp_an(k), exp_seg(k, S5, S4, S3));
      end
    end
  endtask

  task automatic test_midframe_change();
    for (int i = 0; i < 24; i++) begin
      step();
      checks++;
      if (an !== exp_an(k) || seg !== exp_seg(k, S5, S4, S3)) begin
        errors++;
        $display("FAIL midframe_hold k=%0d an=%b seg=%b expected an=%b seg=%b",
                 k, an, seg, exp_an(k), exp_seg(k, S5, S4, S3));
      end
      if (k == 60) digit0 = 4'd7;
    end
    for (int i = 0; i < 24; i++) begin
      step();
      checks++;
      if (an !== exp_an(k) || seg !== exp_seg(k, S7, S4, S3)) begin
        errors++;
        $display("FAIL midframe_new k=%0d an=%b seg=%b expected an=%b seg=%b",
                 k, an, seg, exp_an(k), exp_seg(k, S7, S4, S3));
      end
    end
  endtask

  task automatic test_invalid_digit();
    digit1 = 4'hC;
    for (int i = 0; i < 24; i++) begin
      step();
      checks++;
      if (an !== exp_an(k) || seg !== exp_seg(k, S7, S4, S3)) begin
        errors++;
        $display("FAIL invalid_pending k=%0d an=%b seg=%b expected an=%b seg=%b",
                 k, an, seg, exp_an(k), exp_seg(k, S7, S4, S3));
      end
    end
    for (int i = 0; i < 24; i++) begin
      step();
      checks++;
      if (an !== exp_an(k) || seg !== exp_seg(k, S7, DASH, S3)) begin
        errors++;
        $display("FAIL invalid_dash k=%0d an=%b seg=%b expected an=%b seg=%b",
                 k, an, seg, exp_an(k), exp_seg(k, S7, DASH, S3));
      end
    end
  endtask

  task automatic test_reset_midslot();
    while (k < 163) begin
      step();
      checks++;
      if (an !== exp_an(k) || seg !== exp_seg(k, S7, DASH, S3)) begin
        errors++;
        $display("FAIL pre_midreset k=%0d an=%b seg=%b expected an=%b seg=%b",
                 k, an, seg, exp_an(k), exp_seg(k, S7, DASH, S3));
      end
    end
    checks++;
    if (an !== 4'b1011) begin
      errors++;
      $display("FAIL midreset_slot2 an=%b expected 1011", an);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (an !== 4'b1111 || seg !== BL || dp !== 1'b1) begin
      errors++;
      $display("FAIL midreset_async an=%b seg=%b dp=%b expected an=1111 seg=1111111 dp=1", an, seg, dp);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      checks++;
      if (an !== exp_an(k) || seg !== exp_seg(k, S0, S0, S0)) begin
        errors++;
        $display("FAIL midreset_restart k=%0d an=%b seg=%b expected an=%b seg=%b",
                 k, an, seg, exp_an(k), exp_seg(k, S0, S0, S0));
      end
    end
    for (int i = 0; i < 24; i++) begin
      step();
      checks++;
      if (an !== exp_an(k) || seg !== exp_seg(k, S7, DASH, S3)) begin
        errors++;
        $display("FAIL midreset_live k=%0d an=%b seg=%b expected an=%b seg=%b",
                 k, an, seg, exp_an(k), exp_seg(k, S7, DASH, S3));
      end
    end
  endtask

`ifdef SCORE_LEADING_ZERO_BLANK_EN
  task automatic lz_frame(string name, logic [6:0] s0, logic [6:0] s1, logic [6:0] s2);
    for (int i = 0; i < 24; i++) begin
      step();
      checks++;
      if (an !== exp_an(k) || seg !== exp_seg(k, s0, s1, s2)) begin
        errors++;
        $display("FAIL %s k=%0d an=%b seg=%b expected an=%b seg=%b",
                 name, k, an, seg, exp_an(k), exp_seg(k, s0, s1, s2));
      end
    end
  endtask

  task automatic test_leading_zero();
    digit2 = 4'd0; digit1 = 4'd0; digit0 = 4'd7;
    rst = 1'b1;
    step();
    rst = 1'b0;
    k = 0;
    lz_frame("lz_reset_000", S0, BL, BL);
    lz_frame("lz_007", S7, BL, BL);
    digit0 = 4'd0;
    lz_frame("lz_007_hold", S7, BL, BL);
    digit1 = 4'd5;
    lz_frame("lz_000", S0, BL, BL);
    lz_frame("lz_050", S0, S5, BL);
  endtask
`endif

  initial begin
    test_reset();
    test_first_frame();
    test_live_digits();
    test_midframe_change();
    test_invalid_digit();
    test_reset_midslot();
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    test_leading_zero();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
